// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int PATTERN_LAST = 20;
  localparam int LOOP_W       = 4;

endpackage : led_seq_pkg

// File: rtl/led_seq_ctrl_tick_gen.sv
// Step-rate prescaler: counts 0..period while enabled and pulses tick on the terminal count.
module tick_gen #(
  parameter int PRESCALE_W = 20
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_q, count_d;

  assign tick = enable && (count_q == period);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : tick_gen

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: pointer, traversal direction, loop count, config shadows and a
// two-stage fetch pipe that registers synchronous-read pattern words onto LEDS.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 5,
  parameter int PRESCALE_W = 20
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic                  cmd_step,
  input  logic [ADDR_W-1:0]     cfg_last,
  input  logic                  cfg_pingpong,
  input  logic [3:0]            cfg_loops,
  input  logic [PRESCALE_W-1:0] cfg_period,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     LEDS,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d, adv_dir;
  logic [ADDR_W-1:0]     ptr_q, ptr_d, adv_ptr;
  logic                  adv_wrap;
  logic [LOOP_W-1:0]     loop_cnt_q, loop_cnt_d;
  logic [ADDR_W-1:0]     last_q;
  logic                  pingpong_q;
  logic [LOOP_W-1:0]     loops_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [1:0]            fetch_q;
  logic                  issue;
  logic [DATA_W-1:0]     leds_q;
  logic                  done_q, done_d;
  logic                  tick, start_go, step_go, final_wrap;

  // Command priority is stop > start > step; start is ignored while running.
  assign start_go   = cmd_start && !cmd_stop && (state_q != ST_RUN);
  assign step_go    = cmd_step && !cmd_start && !cmd_stop && (state_q == ST_IDLE);
  assign final_wrap = (loops_q != '0) && ((loop_cnt_q + 1'b1) == loops_q);

  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .enable(state_q == ST_RUN),
    .clear (start_go),
    .period(period_q),
    .tick  (tick)
  );

  // Next position for one advance, independent of whether it is a tick or a step.
  always_comb begin
    adv_ptr  = ptr_q;
    adv_dir  = dir_q;
    adv_wrap = 1'b0;
    if (dir_q == DIR_UP) begin
      if (ptr_q < last_q) begin
        adv_ptr = ptr_q + 1'b1;
      end else begin
        adv_wrap = 1'b1;
        if (pingpong_q) begin
          adv_dir = DIR_DOWN;
          adv_ptr = (last_q == '0) ? '0 : last_q - 1'b1;
        end else begin
          adv_ptr = '0;
        end
      end
    end else begin
      if (ptr_q != '0) begin
        adv_ptr = ptr_q - 1'b1;
      end else begin
        adv_wrap = 1'b1;
        adv_dir  = DIR_UP;
        adv_ptr  = (last_q == '0) ? '0 : ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dir_d      = dir_q;
    loop_cnt_d = loop_cnt_q;
    issue      = 1'b0;
    done_d     = 1'b0;
    if (cmd_stop) begin
      state_d = ST_IDLE;
    end else if (start_go) begin
      state_d    = ST_RUN;
      ptr_d      = '0;
      dir_d      = DIR_UP;
      loop_cnt_d = '0;
      issue      = 1'b1;
    end else if (state_q == ST_RUN && tick) begin
      if (adv_wrap && final_wrap) begin
        // Final wrap parks on the current address; no fetch is issued.
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        ptr_d = adv_ptr;
        dir_d = adv_dir;
        issue = 1'b1;
        if (adv_wrap && loop_cnt_q != '1) begin
          loop_cnt_d = loop_cnt_q + 1'b1;
        end
      end
    end else if (step_go) begin
      ptr_d = adv_ptr;
      dir_d = adv_dir;
      issue = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      dir_q      <= DIR_UP;
      loop_cnt_q <= '0;
      done_q     <= 1'b0;
      fetch_q    <= '0;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dir_q      <= dir_d;
      loop_cnt_q <= loop_cnt_d;
      done_q     <= done_d;
      // Stage 0: address on the bus; stage 1: mem_rdata holds that word.
      fetch_q    <= {fetch_q[0], issue};
      if (fetch_q[1]) begin
        leds_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_q     <= ADDR_W'(PATTERN_LAST);
      pingpong_q <= 1'b0;
      loops_q    <= '0;
      period_q   <= '0;
    end else if (start_go) begin
      last_q     <= cfg_last;
      pingpong_q <= cfg_pingpong;
      loops_q    <= cfg_loops;
      period_q   <= cfg_period;
    end
  end

  assign mem_addr = ptr_q;
  assign LEDS     = leds_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;

endmodule : led_seq_ctrl
